// File: rtl/io_port_responder.sv
// io_port_responder: services CPU IN/OUT requests with a busy/done handshake.
// IN waits for a fresh button press; OUT converts to three BCD digits.
module io_port_responder #(
    parameter int DATA_W   = 32,
    parameter int SW_W     = 4,
    parameter int MAX_DISP = 999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_in,
    input  logic              req_out,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              btn,
    input  logic [SW_W-1:0]   sw,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [3:0]        digit_u,
    output logic [3:0]        digit_d,
    output logic [3:0]        digit_c,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, WAIT_PRESS, CONV, FINISH} stateType;

    stateType          state;
    logic              btnQ;
    logic [DATA_W-1:0] latched;
    logic [3:0]        iter;
    logic [21:0]       shiftReg;
    logic [21:0]       adjusted;
    logic [21:0]       stepped;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction

    // {hundreds, tens, units, 10-bit binary}: correct each digit, then shift
    always_comb begin
        adjusted = {add3(shiftReg[21:18]), add3(shiftReg[17:14]), add3(shiftReg[13:10]), shiftReg[9:0]};
        stepped  = {adjusted[20:0], 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            btnQ     <= 1'b0;
            latched  <= '0;
            iter     <= '0;
            shiftReg <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            digit_u  <= '0;
            digit_d  <= '0;
            digit_c  <= '0;
            overflow <= 1'b0;
        end else begin
            btnQ     <= btn;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_in) begin
                        state <= WAIT_PRESS;
                        busy  <= 1'b1;
                    end else if (req_out) begin
                        state    <= CONV;
                        busy     <= 1'b1;
                        latched  <= wr_data;
                        shiftReg <= {12'd0, wr_data[9:0]};
                        iter     <= '0;
                    end
                end
                WAIT_PRESS: begin
                    // only a rising edge counts, so a button held before the request is ignored
                    if (btn && !btnQ) begin
                        state    <= FINISH;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rd_valid <= 1'b1;
                        rd_data  <= DATA_W'(sw);
                        digit_u  <= 4'(sw);
                        digit_d  <= 4'd0;
                        digit_c  <= 4'd0;
                        overflow <= 1'b0;
                    end
                end
                CONV: begin
                    if (latched > DATA_W'(MAX_DISP)) begin
                        state    <= FINISH;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        digit_u  <= 4'hF;
                        digit_d  <= 4'hF;
                        digit_c  <= 4'hF;
                        overflow <= 1'b1;
                    end else begin
                        shiftReg <= stepped;
                        iter     <= iter + 4'd1;
                        if (iter == 4'd9) begin
                            state    <= FINISH;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            digit_c  <= stepped[21:18];
                            digit_d  <= stepped[17:14];
                            digit_u  <= stepped[13:10];
                            overflow <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: directed scenarios plus random traffic, checked every
// cycle against a latency/arithmetic model of the responder.
module tb_io_port_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_in = 1'b0;
    logic        req_out = 1'b0;
    logic [31:0] wr_data = '0;
    logic        btn = 1'b0;
    logic [3:0]  sw = '0;
    logic        busy, done, rd_valid, overflow;
    logic [31:0] rd_data;
    logic [3:0]  digit_u, digit_d, digit_c;

    int checks = 0;
    int errors = 0;

    io_port_responder dut (
        .clk(clk), .reset(reset), .req_in(req_in), .req_out(req_out),
        .wr_data(wr_data), .btn(btn), .sw(sw), .busy(busy), .done(done),
        .rd_data(rd_data), .rd_valid(rd_valid), .digit_u(digit_u),
        .digit_d(digit_d), .digit_c(digit_c), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request is a wait-for-press or a fixed-latency conversion whose
    // digits come straight from decimal arithmetic.
    logic        mBusy, mDone, mRdv, mOvf, mPrevBtn, mWaitIn;
    logic [31:0] mRd;
    logic [3:0]  mU, mD, mC;
    int unsigned mVal;
    int          mLeft;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy <= 0; mDone <= 0; mRdv <= 0; mOvf <= 0; mPrevBtn <= 0; mWaitIn <= 0;
            mRd <= 0; mU <= 0; mD <= 0; mC <= 0; mVal <= 0; mLeft <= 0;
        end else begin
            mPrevBtn <= btn;
            mDone <= 0;
            mRdv <= 0;
            if (!mBusy && !mDone) begin
                if (req_in) begin
                    mBusy <= 1; mWaitIn <= 1;
                end else if (req_out) begin
                    mBusy <= 1; mWaitIn <= 0; mVal <= wr_data;
                    mLeft <= (wr_data > 999) ? 1 : 10;
                end
            end else if (mBusy && mWaitIn) begin
                if (btn && !mPrevBtn) begin
                    mBusy <= 0; mWaitIn <= 0; mDone <= 1; mRdv <= 1;
                    mRd <= 32'(sw); mU <= sw; mD <= 0; mC <= 0; mOvf <= 0;
                end
            end else if (mBusy) begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    mBusy <= 0; mDone <= 1;
                    if (mVal > 999) begin
                        mU <= 4'hF; mD <= 4'hF; mC <= 4'hF; mOvf <= 1;
                    end else begin
                        mU <= 4'(mVal % 10); mD <= 4'((mVal / 10) % 10);
                        mC <= 4'((mVal / 100) % 10); mOvf <= 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", 32'(busy), 32'(mBusy));
            chk("done", 32'(done), 32'(mDone));
            chk("rd_valid", 32'(rd_valid), 32'(mRdv));
            chk("rd_data", rd_data, mRd);
            chk("digit_u", 32'(digit_u), 32'(mU));
            chk("digit_d", 32'(digit_d), 32'(mD));
            chk("digit_c", 32'(digit_c), 32'(mC));
            chk("overflow", 32'(overflow), 32'(mOvf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue OUT in the current cycle t; report cycles to done and busy cycles seen.
    task automatic doOut(input logic [31:0] v, output int lat, output int busyCnt);
        req_out = 1; wr_data = v; lat = -1; busyCnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done && lat < 0) lat = k;
            @(posedge clk); #1;
            req_out = 0;
            if (lat >= 0) break;
        end
    endtask

    int lat, bc;

    initial begin
        tick(); tick();
        reset = 0;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_digits", {20'd0, digit_c, digit_d, digit_u}, 0);
        chk("reset_rd_data", rd_data, 0);
        tick();

        // reset in the middle of a conversion
        req_out = 1; wr_data = 123;
        tick(); req_out = 0;
        repeat (4) tick();
        reset = 1; #1;
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_digits", {20'd0, digit_c, digit_d, digit_u}, 0);
        chk("midreset_done", 32'(done), 0);
        tick(); reset = 0; tick();
        doOut(7, lat, bc);
        chk("out7_lat", lat, 11);
        chk("out7_digits", {20'd0, digit_c, digit_d, digit_u}, 32'h007);

        doOut(905, lat, bc);
        chk("out905_lat", lat, 11);
        chk("out905_busy", bc, 10);
        chk("out905_digits", {20'd0, digit_c, digit_d, digit_u}, 32'h905);
        chk("out905_ovf", 32'(overflow), 0);
        doOut(1000, lat, bc);
        chk("out1000_lat", lat, 2);
        chk("out1000_busy", bc, 1);
        chk("out1000_digits", {20'd0, digit_c, digit_d, digit_u}, 32'hFFF);
        chk("out1000_ovf", 32'(overflow), 1);

        // IN with the button already held
        btn = 1; tick(); tick();
        req_in = 1; sw = 4'b1010;
        tick(); req_in = 0;
        repeat (5) tick();
        chk("held_busy", 32'(busy), 1);
        chk("held_ovf", 32'(overflow), 1);
        btn = 0; tick();
        btn = 1; tick();
        chk("in_done", 32'(done), 1);
        chk("in_rdv", 32'(rd_valid), 1);
        chk("in_rd_data", rd_data, 10);
        chk("in_digit_u", 32'(digit_u), 10);
        chk("in_ovf", 32'(overflow), 0);
        btn = 0; tick();
        chk("in_done_once", 32'(done), 0);

        // both strobes together, then an OUT while waiting for the press
        req_in = 1; req_out = 1; wr_data = 42; sw = 4'd3;
        tick(); req_in = 0; req_out = 0;
        chk("both_busy", 32'(busy), 1);
        repeat (3) tick();
        req_out = 1; wr_data = 500;
        tick(); req_out = 0;
        repeat (2) tick();
        chk("both_digit_u_held", 32'(digit_u), 10);
        btn = 1; tick();
        chk("both_done", 32'(done), 1);
        chk("both_digit_u", 32'(digit_u), 3);
        btn = 0; tick();
        repeat (12) begin
            chk("no_extra_done", 32'(done), 0);
            tick();
        end
        doOut(0, lat, bc);
        chk("out0_lat", lat, 11);
        chk("out0_digits", {20'd0, digit_c, digit_d, digit_u}, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            req_in  = ($urandom % 10) == 0;
            req_out = ($urandom % 6) == 0;
            wr_data = ($urandom % 4 != 0) ? 32'($urandom % 1000) : $urandom;
            btn     = ($urandom % 3) == 0;
            sw      = 4'($urandom);
            reset   = ($urandom % 300) == 0;
            tick();
        end
        req_in = 0; req_out = 0; btn = 0; reset = 0;
        repeat (20) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
